// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: hex or decimal (double-dabble)
// display, scanned one digit per slot with 16-level PWM brightness.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned PRESCALE_LOG2  = 10,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  dec_mode,
    input  logic                  blank_lz,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic                  busy,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int unsigned VW    = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(VW);
    localparam int unsigned PW    = PRESCALE_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t             state, state_next;
    logic               capture, step, commit;

    logic [VW-1:0]      sh_bin;
    logic [DIGITS-1:0]  sh_dots;
    logic               sh_blank;
    logic [VW-1:0]      bcd;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;

    logic [VW-1:0]      disp_val;
    logic [DIGITS-1:0]  disp_dots;
    logic               disp_ovf;
    logic               disp_blank;

    logic [PW-1:0]      psc;
    logic [IDX_W-1:0]   idx;

    logic [VW-1:0]      adj;
    logic [VW-1:0]      dabble_shift;
    logic               dabble_carry;

    logic [3:0]         cur_nib;
    logic               cur_dot;
    logic               cur_blank;
    logic               run_zero;
    logic [DIGITS-1:0]  onehot;
    logic [7:0]         seg_c;
    logic [DIGITS-1:0]  dig_c;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // State register; busy mirrors "not idle" of the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    state_next = dec_mode ? S_CONV : S_COMMIT;
                end
            end
            S_CONV: begin
                step = 1'b1;
                if (cnt == CNT_W'(VW - 1)) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One double-dabble iteration: add-3 on digits >= 5, then shift in next bit
    always_comb begin
        adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        dabble_carry = adj[VW-1];
        dabble_shift = {adj[VW-2:0], sh_bin[VW-1]};
    end

    // Capture, conversion and atomic commit into the display register
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_bin     <= '0;
            sh_dots    <= '0;
            sh_blank   <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            disp_val   <= '0;
            disp_dots  <= '0;
            disp_ovf   <= 1'b0;
            disp_blank <= 1'b0;
        end else begin
            if (capture) begin
                sh_dots  <= dots;
                sh_blank <= blank_lz;
                cnt      <= '0;
                ovf      <= 1'b0;
                if (dec_mode) begin
                    sh_bin <= value;
                    bcd    <= '0;
                end else begin
                    bcd    <= value;
                end
            end
            if (step) begin
                bcd    <= dabble_shift;
                sh_bin <= {sh_bin[VW-2:0], 1'b0};
                ovf    <= ovf | dabble_carry;
                cnt    <= cnt + CNT_W'(1);
            end
            if (commit) begin
                disp_val   <= bcd;
                disp_dots  <= sh_dots;
                disp_ovf   <= ovf;
                disp_blank <= sh_blank;
            end
        end
    end

    // Slot prescaler and digit index
    always_ff @(posedge CLK) begin
        if (RST) begin
            psc <= '0;
            idx <= '0;
        end else begin
            psc <= psc + PW'(1);
            if (&psc) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Pattern and enable for the digit currently being scanned
    always_comb begin
        cur_nib   = '0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        run_zero  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            run_zero = run_zero & (disp_val[VW-4-4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_val[VW-4-4*i +: 4];
                cur_dot   = disp_dots[int'(DIGITS)-1-i];
                cur_blank = run_zero && (i < int'(DIGITS) - 1);
            end
        end
        seg_c[7]   = ~cur_dot;
        seg_c[6:0] = disp_ovf                  ? 7'b0111111 :
                     (disp_blank && cur_blank) ? 7'h7F      : glyph(cur_nib);
        onehot     = (psc[PW-1 -: 4] < brightness) ? (DIGITS'(1) << idx) : '0;
        dig_c      = DIG_ACTIVE_LOW ? ~onehot : onehot;
    end

    // Registered pins: segment and digit enables change together
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg <= 8'hFF;
            dig <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            seg <= seg_c;
            dig <= dig_c;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment display driver. Captures a value on a load strobe and shows it on `DIGITS` common-anode digits, in either hex or decimal mode. Decimal mode uses a sequential binary-to-BCD converter. The driver scans one digit at a time at a programmable rate and supports 16-level brightness PWM, leading-zero blanking, per-digit dots and an overflow indication. It sits between the application logic and the display pins of the top level.

## Interface
- `DIGITS`, 4: number of digits, 2..8.
- `PRESCALE_LOG2`, 10: each digit slot lasts 2^`PRESCALE_LOG2` cycles; must be ≥ 4.
- `DIG_ACTIVE_LOW`, 1: 1 means an enabled digit drives `dig` bit = 0.

- `CLK`  in  1  clock; all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `value`  in  4*DIGITS  value to display; captured on load.
- `dots`  in  DIGITS  per-digit decimal point, 1 = lit; captured on load.
- `dec_mode`  in  1  0 = hex nibbles, 1 = binary converted to decimal; captured on load.
- `blank_lz`  in  1  leading-zero blanking enable; captured on load.
- `load`  in  1  capture strobe; accepted only when `busy` = 0.
- `brightness`  in  4  duty level 0..15; sampled live.
- `busy`  out  1  capture or conversion in progress.
- `seg`  out  8  active-low segments. Bits [6:0] = g..a; bit [7] = dot.
- `dig`  out  DIGITS  digit enables; polarity set by `DIG_ACTIVE_LOW`.

## Operation
- **Digit order.** Digit index 0 is the leftmost, most significant digit, showing `value[4*DIGITS-1 -: 4]` in hex mode.
- **Load.** When `load`=1 and `busy`=0, capture `value`, `dots`, `dec_mode` and `blank_lz` into shadow registers and raise `busy`. A `load` while `busy`=1 is ignored.
- **Hex mode.** The display register takes the shadow nibbles unchanged. `busy` stays high for exactly 1 cycle.
- **Decimal mode.** Double-dabble conversion, one input bit per cycle, over 4*DIGITS iterations.
  - BCD accumulator width is 4*DIGITS bits, plus a carry-out overflow flag.
  - `busy` stays high for 4*DIGITS+1 cycles, then the result commits.
  - If the input ≥ 10^DIGITS, the overflow flag is set and every digit shows "-": `seg[6:0]` = 7'b0111111, dot still follows `dots`.
- **Commit.** The display register updates atomically in the cycle `busy` falls. A partial result is never displayed.
- **Glyphs.** Standard hex patterns, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - `seg[7]` = ~dot.
- **Leading-zero blanking.** Applies only when `blank_lz`=1 and not in overflow. Digits left of the first nonzero digit show `seg[6:0]`=7'h7F. The rightmost digit is never blanked. Dots are unaffected.
- **Scan.**
  - A prescaler counts 0..2^PRESCALE_LOG2-1 and wraps.
  - On wrap, the digit index increments, wrapping from DIGITS-1 to 0.
  - Exactly one `dig` bit is active, and only while prescaler[top 4 bits] < `brightness`.
  - `brightness`=0 gives all digits inactive; 15 gives 15/16 duty.
- **Reset.**
  - Prescaler = 0, index = 0, `busy` = 0.
  - Display register = all zero digits, no dots, overflow = 0, blanking off.
  - `seg` = 8'hFF and `dig` = all inactive.
- **Reset mid-conversion.** Aborts the conversion. The display register returns to its reset value and no commit occurs.

## Timing
- `seg` and `dig` are registered and change in the same cycle. There is no cycle where one digit is enabled showing another digit's pattern.
- Output latency is 1 cycle from the index/prescaler/display-register state.
- A committed value first appears on `seg` at the next cycle of the current slot, not at the next slot.
- A `load` in the same cycle as a commit (`busy` falling) is ignored. `busy` is still 1 in that cycle.
- A `brightness` change takes effect on the next cycle.

## Test plan
- **Hex display.** DIGITS=4, PRESCALE_LOG2=4, load `value`=16'h1A3F, `dec_mode`=0, `brightness`=15 -> `busy` high 1 cycle. Slots 0..3 show 1111001, 0001000, 0110000, 0001110, each `dig` active 15 of 16 cycles.
- **Decimal conversion.** Load 16'd1234, `dec_mode`=1 -> `busy` high exactly 17 cycles; digits show 1,2,3,4. A second `load` pulsed during `busy` has no effect.
- **Overflow and blanking.** Load 16'd10000 in dec mode -> all digits 0111111. Then load 16'd7 with `blank_lz`=1 -> digits 0..2 = 1111111, digit 3 = 1111000.
- **Brightness and dots.** Set `brightness`=0 -> `dig` all inactive throughout a full scan. Set `brightness`=4 -> each digit active for 4 of 16 cycles. `dots`=4'b0101 -> `seg[7]`=0 on digits 1 and 3 only.
- **Reset mid-conversion.** Assert `RST` 5 cycles into a decimal conversion -> next cycle `busy`=0, `seg`=8'hFF, `dig` inactive; thereafter the display shows 0000.
